// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative tag controller: one lookup per handshake, line fill over req/ack,
// saturating hit/miss/cycle statistics, all-ones address ends the trace.
module assoc_cache_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int OFFSET_W  = 2,
  parameter int INDEX_W   = 8,
  parameter int WAYS      = 2,
  parameter int HIT_CNT_W = 13,
  parameter int CNT_W     = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 req_ready,
  input  logic                 flush,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [ADDR_W-1:0]    resp_addr,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_ack,
  output logic [HIT_CNT_W-1:0] hit_counter,
  output logic [HIT_CNT_W-1:0] miss_counter,
  output logic [CNT_W-1:0]     counter,
  output logic                 done
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_WAIT,
    S_FILL,
    S_DONE
  } state_t;

  state_t                      state;
  logic                        ready_q;
  logic [ADDR_W-1:0]           lat_addr;
  logic [SETS-1:0][WAYS-1:0]   valid;
  logic [TAG_W-1:0]            tags [SETS][WAYS];

  logic [INDEX_W-1:0]          lat_index;
  logic [TAG_W-1:0]            lat_tag;
  logic [WAYS-1:0]             way_hit;
  logic                        lookup_hit;
  logic                        has_free;
  logic [WAY_W-1:0]            free_way;
  logic [WAY_W-1:0]            victim_ptr;
  logic [WAY_W-1:0]            victim_way;
  logic                        accept;
  logic                        flush_en;
  logic                        fill_en;

  assign lat_index = lat_addr[OFFSET_W +: INDEX_W];
  assign lat_tag   = lat_addr[ADDR_W-1 -: TAG_W];

  // A flush in the same cycle as a request wins; the request simply waits.
  assign req_ready = ready_q & ~flush;
  assign accept    = (state == S_IDLE) & req_ready & req_valid;
  assign flush_en  = (state == S_IDLE) & flush;
  assign fill_en   = (state == S_FILL);

  // NOTE: every variable driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    way_hit  = '0;
    has_free = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      way_hit[w] = valid[lat_index][w] && (tags[lat_index][w] == lat_tag);
      if (!valid[lat_index][w]) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    lookup_hit = |way_hit;
    victim_way = has_free ? free_way : victim_ptr;
  end

  // Round-robin pointer only advances when an occupied way is evicted.
  if (WAYS > 1) begin : g_rr
    logic [SETS-1:0][WAY_W-1:0] rr_ptr;

    assign victim_ptr = rr_ptr[lat_index];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rr_ptr <= '0;
      end else if (flush_en) begin
        rr_ptr <= '0;
      end else if (fill_en && !has_free) begin
        rr_ptr[lat_index] <= rr_ptr[lat_index] + 1'b1;
      end
    end
  end else begin : g_no_rr
    assign victim_ptr = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (flush_en) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[lat_index][victim_way] <= 1'b1;
    end
  end

  // NOTE: tag storage is deliberately left without reset; a tag is only ever used behind its valid bit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[lat_index][victim_way] <= lat_tag;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ready_q      <= 1'b0;
      lat_addr     <= '0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_addr    <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      hit_counter  <= '0;
      miss_counter <= '0;
      counter      <= '0;
      done         <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (state != S_DONE && counter != '1) begin
        counter <= counter + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_addr <= req_addr;
            ready_q  <= 1'b0;
            if (&req_addr) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_LOOKUP;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end

        S_LOOKUP: begin
          if (lookup_hit) begin
            state      <= S_IDLE;
            ready_q    <= 1'b1;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_addr  <= lat_addr;
            if (hit_counter != '1) begin
              hit_counter <= hit_counter + 1'b1;
            end
          end else begin
            state    <= S_MISS_WAIT;
            mem_req  <= 1'b1;
            mem_addr <= {lat_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          end
        end

        S_MISS_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_FILL;
          end
        end

        S_FILL: begin
          state      <= S_IDLE;
          ready_q    <= 1'b1;
          resp_valid <= 1'b1;
          resp_hit   <= 1'b0;
          resp_addr  <= lat_addr;
          if (miss_counter != '1) begin
            miss_counter <= miss_counter + 1'b1;
          end
        end

        S_DONE: begin
          ready_q <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Randomised bench for assoc_cache_ctrl against an array-based cache model; a second
// instance with narrow counters exercises statistic saturation on the same stimulus.
module tb_assoc_cache_ctrl;

  localparam int SETS  = 256;
  localparam int WAYS  = 2;
  localparam int TAG_W = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        mem_ack = 1'b0;

  logic        req_ready, resp_valid, resp_hit, mem_req, done;
  logic [31:0] resp_addr, mem_addr;
  logic [12:0] hit_counter, miss_counter;
  logic [20:0] counter;

  logic        s_req_ready, s_resp_valid, s_resp_hit, s_mem_req, s_done;
  logic [31:0] s_resp_addr, s_mem_addr;
  logic [2:0]  s_hit_counter, s_miss_counter;
  logic [5:0]  s_counter;

  int checks = 0;
  int failures = 0;

  bit               m_valid [SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  int               m_ptr   [SETS];
  int               m_hits, m_misses;
  bit               m_done;
  int               edges;

  assoc_cache_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .flush(flush), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_addr(resp_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .hit_counter(hit_counter),
    .miss_counter(miss_counter), .counter(counter), .done(done)
  );

  assoc_cache_ctrl #(.HIT_CNT_W(3), .CNT_W(6)) dut_small (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(s_req_ready),
    .flush(flush), .resp_valid(s_resp_valid), .resp_hit(s_resp_hit), .resp_addr(s_resp_addr),
    .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_ack(mem_ack), .hit_counter(s_hit_counter),
    .miss_counter(s_miss_counter), .counter(s_counter), .done(s_done)
  );

  always #5 clk = ~clk;

  // Cycles since reset, stopped by the bench once it has issued the sentinel.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else if (!m_done) edges <= edges + 1;
  end

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic bit m_lookup(input logic [31:0] addr);
    int s = int'(addr[9:2]);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == addr[31:10]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_fill(input logic [31:0] addr);
    int s = int'(addr[9:2]);
    int way = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
    if (way < 0) begin
      way = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
    m_valid[s][way] = 1'b1;
    m_tag[s][way] = addr[31:10];
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0; req_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_clear(); m_hits = 0; m_misses = 0; m_done = 1'b0;
    @(negedge clk);
  endtask

  // One full transaction; optionally opens with a flush that collides with the request.
  task automatic access(input logic [31:0] addr, input int ack_dly, input bit with_flush);
    bit exp_hit, seen_req;
    int lat, waited, guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL ready_wait: req_ready=%b expected 1", req_ready);
    end
    req_valid = 1'b1; req_addr = addr;
    if (with_flush) begin
      flush = 1'b1; #1;
      checks++;
      if (req_ready !== 1'b0) begin
        failures++; $display("FAIL flush_blocks_ready: req_ready=%b expected 0", req_ready);
      end
      @(negedge clk); flush = 1'b0; m_clear(); #1;
      checks++;
      if (req_ready !== 1'b1) begin
        failures++; $display("FAIL ready_after_flush: req_ready=%b expected 1", req_ready);
      end
    end
    exp_hit = m_lookup(addr);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lookup_cycle: req_ready=%b resp_valid=%b expected 0/0", req_ready, resp_valid);
    end
    lat = 1; waited = 0; seen_req = 1'b0;
    while (resp_valid !== 1'b1 && lat < 60) begin
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (!seen_req) begin
          seen_req = 1'b1;
          checks++;
          if (exp_hit || lat != 2 || mem_addr !== {addr[31:2], 2'b00}) begin
            failures++;
            $display("FAIL mem_req addr=%h: got mem_addr=%h at cycle %0d, expected %s",
                     addr, mem_addr, lat, exp_hit ? "no fetch" : "line address at cycle 2");
          end
        end
        if (waited == ack_dly) mem_ack = 1'b1;
        waited++;
      end
      @(negedge clk); lat++;
    end
    mem_ack = 1'b0;
    checks++;
    if (lat != (exp_hit ? 2 : 4 + ack_dly)) begin
      failures++;
      $display("FAIL latency addr=%h: got %0d cycles expected %0d", addr, lat, exp_hit ? 2 : 4 + ack_dly);
    end
    checks++;
    if (resp_hit !== exp_hit || resp_addr !== addr || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL response addr=%h: hit=%b resp_addr=%h ready=%b expected hit=%b resp_addr=%h ready=1",
               addr, resp_hit, resp_addr, req_ready, exp_hit, addr);
    end
    if (exp_hit) m_hits++;
    else begin m_misses++; m_fill(addr); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_addr !== '0 ||
        mem_req !== 1'b0 || mem_addr !== '0 || hit_counter !== '0 || miss_counter !== '0 ||
        counter !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: ready=%b rv=%b rh=%b ra=%h mreq=%b ma=%h hit=%0d miss=%0d cnt=%0d done=%b expected all zero",
               req_ready, resp_valid, resp_hit, resp_addr, mem_req, mem_addr, hit_counter,
               miss_counter, counter, done);
    end
    rst = 1'b0;
    m_clear(); m_hits = 0; m_misses = 0; m_done = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || counter !== 21'd1) begin
      failures++;
      $display("FAIL ready_after_reset: req_ready=%b counter=%0d expected 1/1", req_ready, counter);
    end
  endtask

  task automatic test_basic();
    do_reset();
    access(32'h0000_4138, 1, 1'b0);
    access(32'h0000_4139, 0, 1'b0);
    checks++;
    if (hit_counter !== 13'd1 || miss_counter !== 13'd1 || counter !== 21'(edges)) begin
      failures++;
      $display("FAIL basic_counters: hit=%0d miss=%0d cnt=%0d expected 1/1/%0d",
               hit_counter, miss_counter, counter, edges);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    access(32'h0000_0010, 0, 1'b0);
    access(32'h0000_0410, 2, 1'b0);
    access(32'h0000_0810, 0, 1'b0);
    access(32'h0000_0010, 1, 1'b0);
    access(32'h0000_0810, 0, 1'b0);
    checks++;
    if (hit_counter !== 13'd1 || miss_counter !== 13'd4) begin
      failures++;
      $display("FAIL conflict_counters: hit=%0d miss=%0d expected 1/4", hit_counter, miss_counter);
    end
  endtask

  task automatic test_flush();
    do_reset();
    access(32'h0000_4138, 0, 1'b0);
    access(32'h0000_4138, 0, 1'b1);
    checks++;
    if (hit_counter !== 13'd0 || miss_counter !== 13'd2) begin
      failures++;
      $display("FAIL flush_counters: hit=%0d miss=%0d expected 0/2", hit_counter, miss_counter);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    access(32'h0000_0080, 0, 1'b0);
    for (int i = 0; i < 9; i++) access(32'h0000_0080 | 32'(i % 4), 0, 1'b0);
    checks++;
    if (hit_counter !== 13'd9 || s_hit_counter !== 3'd7 || s_miss_counter !== 3'd1) begin
      failures++;
      $display("FAIL hit_saturation: hit=%0d small_hit=%0d small_miss=%0d expected 9/7/1",
               hit_counter, s_hit_counter, s_miss_counter);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    do_reset();
    access(32'h0000_0200, 0, 1'b0);
    start = edges;
    for (int i = 0; i < 4; i++) access(32'h0000_0200 | 32'(i), 0, 1'b0);
    checks++;
    if (edges - start != 8) begin
      failures++;
      $display("FAIL hit_throughput: 4 hits took %0d cycles expected 8", edges - start);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      access(a, $urandom_range(0, 3), $urandom_range(0, 9) == 0);
    end
    checks++;
    if (hit_counter !== 13'(m_hits) || miss_counter !== 13'(m_misses) || counter !== 21'(edges)) begin
      failures++;
      $display("FAIL random_counters: hit=%0d miss=%0d cnt=%0d expected %0d/%0d/%0d",
               hit_counter, miss_counter, counter, m_hits, m_misses, edges);
    end
    checks++;
    if (s_hit_counter !== 3'(sat(m_hits, 7)) || s_miss_counter !== 3'(sat(m_misses, 7)) ||
        s_counter !== 6'(sat(edges, 63))) begin
      failures++;
      $display("FAIL random_saturation: hit=%0d miss=%0d cnt=%0d expected %0d/%0d/%0d",
               s_hit_counter, s_miss_counter, s_counter, sat(m_hits, 7), sat(m_misses, 7), sat(edges, 63));
    end
  endtask

  task automatic test_sentinel();
    int frozen, pulses;
    do_reset();
    access(32'h0000_1000, 0, 1'b0);
    access(32'h0000_1001, 0, 1'b0);
    access(32'h0000_2000, 1, 1'b0);
    req_valid = 1'b1; req_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    m_done = 1'b1; req_valid = 1'b0; frozen = edges;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0 || s_done !== 1'b1) begin
      failures++;
      $display("FAIL sentinel_done: done=%b ready=%b resp_valid=%b expected 1/0/0", done, req_ready, resp_valid);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      req_valid = 1'b1; req_addr = 32'h0000_1000;
      flush = (i == 3); mem_ack = i[0];
      @(negedge clk);
      if (resp_valid === 1'b1 || mem_req === 1'b1 || req_ready === 1'b1) pulses++;
    end
    req_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    checks++;
    if (pulses != 0 || done !== 1'b1) begin
      failures++;
      $display("FAIL done_ignores: %0d active cycles, done=%b expected 0 active, done=1", pulses, done);
    end
    checks++;
    if (counter !== 21'(frozen) || hit_counter !== 13'd1 || miss_counter !== 13'd2) begin
      failures++;
      $display("FAIL done_frozen: cnt=%0d hit=%0d miss=%0d expected %0d/1/2",
               counter, hit_counter, miss_counter, frozen);
    end
  endtask

  task automatic test_reset_mid_miss();
    int guard;
    do_reset();
    access(32'h0000_4138, 0, 1'b0);
    req_valid = 1'b1; req_addr = 32'h0000_8000;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (mem_req !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
    checks++;
    if (mem_req !== 1'b1) begin
      failures++; $display("FAIL mid_miss_req: mem_req=%b expected 1", mem_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || req_ready !== 1'b0 || resp_valid !== 1'b0 ||
        resp_addr !== '0 || hit_counter !== '0 || miss_counter !== '0 || counter !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: mreq=%b ma=%h ready=%b rv=%b ra=%h hit=%0d miss=%0d cnt=%0d done=%b expected all zero",
               mem_req, mem_addr, req_ready, resp_valid, resp_addr, hit_counter, miss_counter, counter, done);
    end
    @(negedge clk);
    rst = 1'b0;
    m_clear(); m_hits = 0; m_misses = 0; m_done = 1'b0;
    @(negedge clk);
    access(32'h0000_4138, 0, 1'b0);
    checks++;
    if (resp_hit !== 1'b0 || miss_counter !== 13'd1) begin
      failures++;
      $display("FAIL refetch_after_reset: hit=%b miss=%0d expected 0/1", resp_hit, miss_counter);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_flush();
    test_saturation();
    test_back_to_back();
    test_random();
    test_sentinel();
    test_reset_mid_miss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
